// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: zero-register index,
// default geometry, address-width helper and ABI register names.
package regfile_sb_pkg;

    localparam int unsigned ZERO_IDX  = 0;
    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned DEF_NREGS = 32;

    // A single-entry file still needs a one-bit address bus.
    function automatic int unsigned reg_aw(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 1;
    localparam int unsigned REG_SP   = 2;
    localparam int unsigned REG_GP   = 3;
    localparam int unsigned REG_TP   = 4;
    localparam int unsigned REG_T0   = 5;
    localparam int unsigned REG_T1   = 6;
    localparam int unsigned REG_T2   = 7;
    localparam int unsigned REG_S0   = 8;
    localparam int unsigned REG_S1   = 9;
    localparam int unsigned REG_A0   = 10;
    localparam int unsigned REG_A1   = 11;
    localparam int unsigned REG_A2   = 12;
    localparam int unsigned REG_A3   = 13;
    localparam int unsigned REG_A4   = 14;
    localparam int unsigned REG_A5   = 15;
    localparam int unsigned REG_A6   = 16;
    localparam int unsigned REG_A7   = 17;

endpackage

// File: rtl/regfile_sb_sb_table.sv
// Pending-write scoreboard: one bit per register with flush > reserve > clear
// priority, plus per-port busy lookup masked for x0 and out-of-range addresses.
module sb_table
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NREGS    = DEF_NREGS,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned AW       = reg_aw(DEF_NREGS),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic [NREAD*AW-1:0] lk_addr,
    output logic [NREAD-1:0]    lk_busy,
    output logic [NREGS-1:0]    pending
);

    localparam logic [AW:0] LIM = (AW+1)'(NREGS);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_nxt;
    logic             w_rsv_ok;

    assign w_rsv_ok = rsv_en && ({1'b0, rsv_addr} < LIM)
                      && !((ZERO_REG != 0) && (rsv_addr == AW'(ZERO_IDX)));

    // Reserve is applied after clear so a same-cycle retire/issue stays pending.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (clr_en && (clr_addr == AW'(r))) w_pend_nxt[r] = 1'b0;
            if (w_rsv_ok && (rsv_addr == AW'(r))) w_pend_nxt[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_pend <= '0;
        else if (flush) r_pend <= '0;
        else            r_pend <= w_pend_nxt;
    end

    assign pending = r_pend;

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_lk
        logic [AW-1:0] w_a;
        logic          w_ok;
        assign w_a  = lk_addr[gi*AW +: AW];
        assign w_ok = ({1'b0, w_a} < LIM)
                      && !((ZERO_REG != 0) && (w_a == AW'(ZERO_IDX)));
        assign lk_busy[gi] = w_ok ? r_pend[w_a] : 1'b0;
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read register file with async clear, optional write-to-read
// bypass and a pending-write scoreboard driving the decode stall signal.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int unsigned XLEN     = DEF_XLEN,
    parameter  int unsigned NREGS    = DEF_NREGS,
    parameter  int unsigned NREAD    = 2,
    parameter  int unsigned ZERO_REG = 1,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned AW       = reg_aw(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   raddr,
    input  logic [NREAD-1:0]      rd_en,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic [NREAD-1:0]      rbusy,
    output logic                  hazard,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  flush,
    output logic [NREGS-1:0]      pending
);

    localparam logic [AW:0] LIM = (AW+1)'(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic             w_wr_ok;
    logic [NREAD-1:0] w_lk_busy;

    assign w_wr_ok = we && ({1'b0, waddr} < LIM)
                     && !((ZERO_REG != 0) && (waddr == AW'(ZERO_IDX)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[waddr] <= wdata;
        end
    end

    sb_table #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clr_en   (we),
        .clr_addr (waddr),
        .lk_addr  (raddr),
        .lk_busy  (w_lk_busy),
        .pending  (pending)
    );

    // Bypass is gated by rst so reads stay at zero while the file is held in reset.
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0] w_a;
        logic          w_ok;
        logic          w_hit;
        assign w_a   = raddr[gi*AW +: AW];
        assign w_ok  = ({1'b0, w_a} < LIM)
                       && !((ZERO_REG != 0) && (w_a == AW'(ZERO_IDX)));
        assign w_hit = (BYPASS != 0) && rst && we && (waddr == w_a);
        assign rdata[gi*XLEN +: XLEN] = !w_ok ? '0 : (w_hit ? wdata : r_regs[w_a]);
        assign rbusy[gi] = w_lk_busy[gi] & ~w_hit;
    end

    assign hazard = |(rbusy & rd_en);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus random checks of regfile_sb (24 regs, 3 ports) with and without
// bypass, against an array-based reference model of the register/scoreboard rules.
module tb_regfile_sb;

    localparam int NR = 24;
    localparam int NP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] raddr;
    logic [2:0]  rd_en;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    logic [95:0] rdata_b, rdata_n;
    logic [2:0]  rbusy_b, rbusy_n;
    logic        hazard_b, hazard_n;
    logic [23:0] pending_b, pending_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [NR];
    bit   [23:0] m_pend;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(NR), .NREAD(NP), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .raddr(raddr), .rd_en(rd_en), .rdata(rdata_b),
        .rbusy(rbusy_b), .hazard(hazard_b), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .pending(pending_b));

    regfile_sb #(.XLEN(32), .NREGS(NR), .NREAD(NP), .ZERO_REG(1), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .raddr(raddr), .rd_en(rd_en), .rdata(rdata_n),
        .rbusy(rbusy_n), .hazard(hazard_n), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .pending(pending_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_pend = '0;
    endtask

    task automatic model_update();
        if (!rst) return;
        if (flush) m_pend = '0;
        else begin
            if (we && waddr < NR) m_pend[waddr] = 1'b0;
            if (rsv_en && rsv_addr < NR && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
        if (we && waddr < NR && waddr != 0) m_regs[waddr] = wdata;
    endtask

    function automatic bit fwd(input int a, input bit byp);
        return byp && rst && we && (int'(waddr) == a);
    endfunction

    function automatic logic [31:0] exp_rd(input int a, input bit byp);
        if (a >= NR || a == 0) return '0;
        if (fwd(a, byp)) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        if (a >= NR || a == 0) return 1'b0;
        if (fwd(a, byp)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic check_all(input string tag);
        logic hz_b, hz_n;
        hz_b = 1'b0;
        hz_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            int a;
            a = int'(raddr[p*5 +: 5]);
            chk({tag, "_rdata_byp"}, rdata_b[p*32 +: 32], exp_rd(a, 1'b1));
            chk({tag, "_rdata_nob"}, rdata_n[p*32 +: 32], exp_rd(a, 1'b0));
            chk({tag, "_rbusy_byp"}, 32'(rbusy_b[p]), 32'(exp_busy(a, 1'b1)));
            chk({tag, "_rbusy_nob"}, 32'(rbusy_n[p]), 32'(exp_busy(a, 1'b0)));
            hz_b |= exp_busy(a, 1'b1) & rd_en[p];
            hz_n |= exp_busy(a, 1'b0) & rd_en[p];
        end
        chk({tag, "_hazard_byp"}, 32'(hazard_b), 32'(hz_b));
        chk({tag, "_hazard_nob"}, 32'(hazard_n), 32'(hz_n));
        chk({tag, "_pending_byp"}, 32'(pending_b), 32'(m_pend));
        chk({tag, "_pending_nob"}, 32'(pending_n), 32'(m_pend));
    endtask

    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        rsv_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_ra(input int p, input int a);
        raddr[p*5 +: 5] = a[4:0];
    endtask

    initial begin
        rst = 1'b0;
        idle();
        raddr = '0; rd_en = '0; waddr = '0; wdata = '0; rsv_addr = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Preload then asynchronous reset in mid-cycle
        we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF; rsv_en = 1'b1; rsv_addr = 6;
        cyc("preload");
        idle(); set_ra(0, 5); set_ra(1, 6); rd_en = 3'b011;
        #1;
        check_all("pre");
        chk("pre_rd5", rdata_b[31:0], 32'hDEADBEEF);
        chk("pre_pend6", 32'(pending_b[6]), 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_rd5_byp", rdata_b[31:0], 32'h0);
        chk("arst_rd5_nob", rdata_n[31:0], 32'h0);
        chk("arst_pending", 32'(pending_b), 32'h0);
        check_all("arst");
        #1;
        rst = 1'b1;

        // Write/read and x0
        rd_en = '0;
        we = 1'b1; waddr = 3; wdata = 32'h1234;
        cyc("w3");
        we = 1'b1; waddr = 0; wdata = 32'hFFFF; rsv_en = 1'b1; rsv_addr = 0;
        cyc("w0");
        idle(); set_ra(0, 3); set_ra(1, 0);
        #1;
        chk("rd3_byp", rdata_b[31:0], 32'h1234);
        chk("rd3_nob", rdata_n[31:0], 32'h1234);
        chk("rd0", rdata_b[63:32], 32'h0);
        chk("pend0", 32'(pending_b[0]), 32'd0);

        // Same-cycle bypass
        set_ra(1, 7); we = 1'b1; waddr = 7; wdata = 32'hA5A5A5A5;
        #1;
        chk("byp_same", rdata_b[63:32], 32'hA5A5A5A5);
        chk("nob_same", rdata_n[63:32], 32'h0);
        cyc("byp");
        idle();
        #1;
        chk("nob_next", rdata_n[63:32], 32'hA5A5A5A5);

        // Scoreboard hazard and retire
        rsv_en = 1'b1; rsv_addr = 9;
        cyc("rsv9");
        idle(); set_ra(0, 9); rd_en = 3'b001;
        #1;
        chk("busy9_byp", 32'(rbusy_b[0]), 32'd1);
        chk("haz9_byp", 32'(hazard_b), 32'd1);
        chk("haz9_nob", 32'(hazard_n), 32'd1);
        we = 1'b1; waddr = 9; wdata = 32'h99;
        #1;
        chk("wb9_busy_byp", 32'(rbusy_b[0]), 32'd0);
        chk("wb9_haz_byp", 32'(hazard_b), 32'd0);
        chk("wb9_busy_nob", 32'(rbusy_n[0]), 32'd1);
        chk("wb9_haz_nob", 32'(hazard_n), 32'd1);
        cyc("wb9");
        idle();
        #1;
        chk("pend9_clr", 32'(pending_b[9]), 32'd0);
        rsv_en = 1'b1; rsv_addr = 9;
        cyc("rsv9b");
        idle(); rd_en = 3'b000;
        #1;
        chk("rden0_busy", 32'(rbusy_b[0]), 32'd1);
        chk("rden0_haz", 32'(hazard_b), 32'd0);

        // Simultaneous reserve/retire, then flush beating reserve
        rsv_en = 1'b1; rsv_addr = 4;
        cyc("rsv4");
        rsv_en = 1'b1; rsv_addr = 4; we = 1'b1; waddr = 4; wdata = 32'h44;
        cyc("rsv_wb4");
        idle();
        #1;
        chk("pend4_kept", 32'(pending_b[4]), 32'd1);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 8;
        cyc("flush");
        idle();
        #1;
        chk("flush_pend_byp", 32'(pending_b), 32'h0);
        chk("flush_pend_nob", 32'(pending_n), 32'h0);

        // Out-of-range addresses and independent ports on a 24-entry file
        we = 1'b1; waddr = 27; wdata = 32'h77777777; rsv_en = 1'b1; rsv_addr = 27;
        cyc("oor_w");
        idle(); set_ra(0, 30); set_ra(1, 27); rd_en = 3'b111;
        #1;
        chk("rd30", rdata_b[31:0], 32'h0);
        chk("busy30", 32'(rbusy_b[0]), 32'd0);
        chk("rd27", rdata_n[63:32], 32'h0);
        chk("oor_pend", 32'(pending_b), 32'h0);
        we = 1'b1; waddr = 1; wdata = 32'h11111111;
        cyc("w1");
        we = 1'b1; waddr = 2; wdata = 32'h22222222;
        cyc("w2");
        idle(); set_ra(0, 1); set_ra(1, 1); set_ra(2, 2);
        #1;
        chk("p0_r1", rdata_n[31:0], 32'h11111111);
        chk("p1_r1", rdata_n[63:32], 32'h11111111);
        chk("p2_r2", rdata_n[95:64], 32'h22222222);
        check_all("ports");

        // Random traffic with occasional asynchronous reset
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) set_ra(p, int'($urandom_range(0, 31)));
            rd_en    = 3'($urandom);
            we       = 1'($urandom);
            waddr    = 5'($urandom_range(0, 31));
            wdata    = $urandom;
            rsv_en   = 1'($urandom);
            rsv_addr = 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 15) == 0);
            cyc("rnd");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst = 1'b0;
                model_reset();
                #1;
                check_all("rnd_arst");
                #1;
                rst = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
